// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - bus bundle between the fetch unit, instruction memory and decode
//
// Purpose: groups the imem request/response channel, the decode-side instruction channel
// and the redirect inputs so the fetch unit sees them through a single port.
// Ports (by modport):
//   master (fetch unit): drives imem_req_valid/imem_req_addr and the instr_* outputs,
//                        samples imem_req_ready, imem_rsp_*, PCSrc/PCTarget and instr_ready.
//   slave  (environment): the mirror image of master.
interface fetch_unit_if #(
  parameter int AW = 32
);
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          PCSrc;
  logic [AW-1:0] PCTarget;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          func75;

  modport master (
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr, instr_pc, opcode, funct3, func75,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  PCSrc, PCTarget, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr, instr_pc, opcode, funct3, func75,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output PCSrc, PCTarget, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with response FIFO and redirect squash
//
// Purpose: issues in-order word fetches from pc, tracks the PC of every in-flight request,
// buffers responses in a DEPTH-entry FIFO toward decode, and on a PCSrc redirect restarts
// fetching at PCTarget while discarding responses to requests issued before the redirect.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master: imem request/response, redirect, decode instruction channel
// Parameters: AW (address width), DEPTH (FIFO entries and fetch credit, power of 2, >=2),
//   RESET_PC (pc after reset).
module fetch_unit #(
  parameter int            AW       = 32,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {RUN, FLUSH} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic          req_valid_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] drop;

  logic [AW-1:0] fifo_pc   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] fifo_head;
  logic [PW-1:0] fifo_tail;

  logic [AW-1:0] inflight_pc [DEPTH];
  logic [PW-1:0] inflight_head;
  logic [PW-1:0] inflight_tail;

  logic          accept;
  logic          rsp;
  logic          redirect;
  logic          push;
  logic          pop;
  logic          issue;
  logic          head_valid;
  logic [AW-1:0] target;
  logic [AW-1:0] pc_n;
  logic [CW-1:0] out_run;
  logic [CW-1:0] out_n;
  logic [CW-1:0] count_n;
  logic [CW-1:0] drop_n;
  state_t        state_n;
  logic          credit_n;
  logic [31:0]   instr_w;

  always_comb begin
    accept     = req_valid_q & bus.imem_req_ready;
    rsp        = bus.imem_rsp_valid;
    redirect   = bus.PCSrc;
    head_valid = (fifo_count != '0);
    pop        = head_valid & bus.instr_ready;
    // Responses only reach the FIFO while running; a same-cycle redirect squashes them.
    push       = rsp & (state == RUN) & ~redirect;
    issue      = accept & ~redirect;
    target     = bus.PCTarget & ~AW'(3);
    out_run    = outstanding + CW'(accept) - CW'(rsp);

    // Redirect beats a same-cycle accept: the accepted request is squashed, not followed.
    if (redirect) begin
      pc_n = target;
    end else if (accept) begin
      pc_n = pc + AW'(4);
    end else begin
      pc_n = pc;
    end

    if (redirect) begin
      count_n = '0;
    end else begin
      count_n = fifo_count + CW'(push) - CW'(pop);
    end

    out_n   = '0;
    drop_n  = drop;
    state_n = state;
    case (state)
      RUN: begin
        if (redirect) begin
          // Everything still in flight becomes stale and is counted off in FLUSH.
          drop_n  = out_run;
          state_n = (out_run != '0) ? FLUSH : RUN;
        end else begin
          out_n = out_run;
        end
      end
      FLUSH: begin
        if (rsp) begin
          drop_n = drop - CW'(1);
        end
        state_n = (drop_n == '0) ? RUN : FLUSH;
      end
      default: state_n = RUN;
    endcase

    credit_n = ({1'b0, out_n} + {1'b0, count_n}) < (CW + 1)'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pc            <= RESET_PC;
      req_valid_q   <= 1'b0;
      outstanding   <= '0;
      fifo_count    <= '0;
      drop          <= '0;
      fifo_head     <= '0;
      fifo_tail     <= '0;
      inflight_head <= '0;
      inflight_tail <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      // Request valid is registered from next-cycle credit so it never glitches.
      req_valid_q <= (state_n == RUN) && credit_n;
      outstanding <= out_n;
      fifo_count  <= count_n;
      drop        <= drop_n;
      if (redirect) begin
        fifo_head     <= '0;
        fifo_tail     <= '0;
        inflight_head <= '0;
        inflight_tail <= '0;
      end else begin
        if (issue) begin
          inflight_pc[inflight_tail] <= pc;
          inflight_tail              <= inflight_tail + PW'(1);
        end
        if (push) begin
          fifo_pc[fifo_tail]   <= inflight_pc[inflight_head];
          fifo_data[fifo_tail] <= bus.imem_rsp_data;
          fifo_tail            <= fifo_tail + PW'(1);
          inflight_head        <= inflight_head + PW'(1);
        end
        if (pop) begin
          fifo_head <= fifo_head + PW'(1);
        end
      end
    end
  end

  assign instr_w = head_valid ? fifo_data[fifo_head] : NOP;

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = head_valid;
  assign bus.instr          = instr_w;
  assign bus.instr_pc       = head_valid ? fifo_pc[fifo_head] : '0;
  assign bus.opcode         = instr_w[6:0];
  assign bus.funct3         = instr_w[14:12];
  assign bus.func75         = instr_w[30];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.AW(AW)) bus ();

  fetch_unit #(.AW(AW), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int max_infl = 0;
  int first_rsp = -1;
  int first_iv = -1;
  bit hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] acc_q[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_ins[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hdead_beef;
  endfunction

  // One clock: observe at negedge, respond from the 1-cycle-latency imem model after posedge.
  task automatic tick();
    logic a;
    logic [31:0] aa;
    int infl;
    @(negedge clk);
    a  = bus.imem_req_valid && bus.imem_req_ready && !rst;
    aa = bus.imem_req_addr;
    if (!rst) begin
      if (bus.instr_valid && bus.instr_ready) begin
        del_pc.push_back(bus.instr_pc);
        del_ins.push_back(bus.instr);
      end
      if (a) acc_q.push_back(aa);
      infl = pend.size() + (bus.imem_rsp_valid ? 1 : 0);
      if (infl > max_infl) max_infl = infl;
      if (bus.imem_rsp_valid && first_rsp < 0) first_rsp = cyc;
      if (bus.instr_valid && first_iv < 0) first_iv = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (a) pend.push_back(aa);
    if (!rst && !hold && pend.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = pend.pop_front();
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic clear_tb();
    pend.delete();
    acc_q.delete();
    del_pc.delete();
    del_ins.delete();
    max_infl  = 0;
    first_rsp = -1;
    first_iv  = -1;
    hold      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_tb();
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.PCSrc          = 1'b0;
    bus.PCTarget       = 32'h0;
    bus.instr_ready    = 1'b1;

    // Reset values
    do_reset();
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_instr", bus.instr, 32'h13);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    check("rst_opcode", bus.opcode, 7'h13);
    check("rst_funct3", bus.funct3, 3'h0);
    check("rst_func75", bus.func75, 1'b0);

    // 1: streaming fetch, data = address
    repeat (24) tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_acc%0d", i), qget(acc_q, i), 32'(4 * i));
      check($sformatf("t1_pc%0d", i), qget(del_pc, i), 32'(4 * i));
      check($sformatf("t1_ins%0d", i), qget(del_ins, i), 32'(4 * i));
    end
    check("t1_max_inflight_le2", max_infl <= 2, 1'b1);
    check("t1_first_latency", first_iv - first_rsp, 64'd1);

    // 2: backpressure from decode
    do_reset();
    bus.instr_ready = 1'b0;
    repeat (10) tick();
    check("t2_accepts", acc_q.size(), 64'd2);
    check("t2_req_valid", bus.imem_req_valid, 1'b0);
    check("t2_instr_valid", bus.instr_valid, 1'b1);
    check("t2_head_pc", bus.instr_pc, 32'h0);
    bus.instr_ready = 1'b1;
    repeat (24) tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_acc%0d", i), qget(acc_q, i), 32'(4 * i));
      check($sformatf("t2_pc%0d", i), qget(del_pc, i), 32'(4 * i));
    end

    // 3: redirect with two fetches (8, 12) in flight
    do_reset();
    hold = 1'b1;
    bus.PCSrc = 1'b1;
    bus.PCTarget = 32'h8;
    tick();
    bus.PCSrc = 1'b0;
    repeat (4) tick();
    check("t3_accepts", acc_q.size(), 64'd2);
    check("t3_acc0", qget(acc_q, 0), 32'h8);
    check("t3_acc1", qget(acc_q, 1), 32'hc);
    check("t3_req_valid_full", bus.imem_req_valid, 1'b0);
    bus.PCSrc = 1'b1;
    bus.PCTarget = 32'h100;
    tick();
    bus.PCSrc = 1'b0;
    check("t3_flush_req_valid", bus.imem_req_valid, 1'b0);
    hold = 1'b0;
    repeat (20) tick();
    check("t3_first_pc", qget(del_pc, 0), 32'h100);
    check("t3_first_ins", qget(del_ins, 0), 32'h100);
    check("t3_second_pc", qget(del_pc, 1), 32'h104);
    check("t3_acc_after", qget(acc_q, 2), 32'h100);

    // 4: misaligned redirect while FIFO full, nothing outstanding
    do_reset();
    bus.instr_ready = 1'b0;
    repeat (10) tick();
    check("t4_full_valid", bus.instr_valid, 1'b1);
    check("t4_full_req_valid", bus.imem_req_valid, 1'b0);
    bus.PCSrc = 1'b1;
    bus.PCTarget = 32'h203;
    tick();
    bus.PCSrc = 1'b0;
    check("t4_flushed", bus.instr_valid, 1'b0);
    check("t4_run_req_valid", bus.imem_req_valid, 1'b1);
    check("t4_addr", bus.imem_req_addr, 32'h200);
    bus.instr_ready = 1'b1;
    repeat (10) tick();
    check("t4_first_pc", qget(del_pc, 0), 32'h200);
    check("t4_acc", qget(acc_q, 2), 32'h200);

    // 5: imem stall, redirect mid-stall
    do_reset();
    bus.imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_stall_valid%0d", i), bus.imem_req_valid, 1'b1);
      check($sformatf("t5_stall_addr%0d", i), bus.imem_req_addr, 32'h0);
      tick();
    end
    bus.PCSrc = 1'b1;
    bus.PCTarget = 32'h40;
    tick();
    bus.PCSrc = 1'b0;
    check("t5_redir_addr", bus.imem_req_addr, 32'h40);
    check("t5_redir_valid", bus.imem_req_valid, 1'b1);
    bus.imem_req_ready = 1'b1;
    repeat (10) tick();
    check("t5_acc0", qget(acc_q, 0), 32'h40);
    check("t5_pc0", qget(del_pc, 0), 32'h40);

    // 6: reset mid-stream with one fetch outstanding
    do_reset();
    tick();
    tick();
    check("t6_pre_req_valid", bus.imem_req_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_instr_valid", bus.instr_valid, 1'b0);
    check("t6_req_valid", bus.imem_req_valid, 1'b0);
    check("t6_instr", bus.instr, 32'h13);
    check("t6_instr_pc", bus.instr_pc, 32'h0);
    check("t6_opcode", bus.opcode, 7'h13);
    rst = 1'b0;
    clear_tb();
    repeat (12) tick();
    check("t6_acc0", qget(acc_q, 0), 32'h0);
    check("t6_pc0", qget(del_pc, 0), 32'h0);
    check("t6_pc1", qget(del_pc, 1), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
